// File: rtl/inst_rom_resp_pkg.sv
// rtl/inst_rom_resp_pkg.sv - shared fetch-bus widths, constants and loader states
package inst_rom_resp_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord    = 32'h0000_0000;
  localparam logic               ChipEnable  = 1'b1;
  localparam logic               ChipDisable = 1'b0;

  typedef enum logic [1:0] {
    LdIdle = 2'd0,
    LdLoad = 2'd1,
    LdDone = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_mem_sp.sv
// rtl/inst_mem_sp.sv - 2^AW x 32 array, one sync write port, one sync read port
module inst_mem_sp #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [1<<AW];
  logic [31:0] rdata_q;

  // No reset on the array: contents must survive reset and reloads
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom_resp.sv
// rtl/inst_rom_resp.sv - instruction fetch responder with byte-serial boot loader
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] addr_i,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o,
  output logic                   addr_err_o,
  input  logic                   ld_start_i,
  input  logic                   ld_valid_i,
  input  logic [7:0]             ld_byte_i,
  input  logic                   ld_last_i,
  output logic                   ld_ready_o,
  output logic                   ld_busy_o,
  output logic                   ld_done_o,
  output logic [DEPTH_LOG2:0]    ld_count_o
);

  ld_state_e             state_q, state_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [31:0]           wbuf_q, wbuf_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  fvalid_q, fvalid_d;
  logic                  ferr_q, ferr_d;

  logic [DEPTH_LOG2-1:0] wptr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  accept, wlast, addr_bad, fetch_en, mem_re;

  // Words are written in order, so the write pointer is the low bits of the count
  assign wptr   = count_q[DEPTH_LOG2-1:0];
  assign accept = (state_q == LdLoad) && ld_valid_i && !ld_start_i;
  assign wlast  = accept && ((bcnt_q == 2'd3) || ld_last_i);
  assign wdata  = wbuf_q | ({24'h0, ld_byte_i} << (5'd24 - {bcnt_q, 3'b000}));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    wbuf_d  = wbuf_q;
    count_d = count_q;
    if (ld_start_i) begin
      state_d = LdLoad;
      bcnt_d  = 2'd0;
      wbuf_d  = '0;
      count_d = '0;
    end else if (accept) begin
      if (wlast) begin
        bcnt_d  = 2'd0;
        wbuf_d  = '0;
        count_d = count_q + 1'b1;
        if (ld_last_i || (&wptr)) state_d = LdDone;
      end else begin
        bcnt_d = bcnt_q + 2'd1;
        wbuf_d = wdata;
      end
    end
  end

  assign addr_bad = (|addr_i[1:0]) || (|addr_i[InstAddrBus-1:DEPTH_LOG2+2]);
  assign fetch_en = (ce_i == ChipEnable) && (state_q != LdLoad);
  assign mem_re   = fetch_en && !addr_bad;
  assign fvalid_d = fetch_en;
  assign ferr_d   = fetch_en && addr_bad;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= LdIdle;
      bcnt_q   <= 2'd0;
      wbuf_q   <= '0;
      count_q  <= '0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      wbuf_q   <= wbuf_d;
      count_q  <= count_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  inst_mem_sp #(.AW(DEPTH_LOG2)) u_mem (
    .clk_i   (clk_i),
    .we_i    (wlast && rst_i),
    .waddr_i (wptr),
    .wdata_i (wdata),
    .re_i    (mem_re),
    .raddr_i (addr_i[DEPTH_LOG2+1:2]),
    .rdata_o (rdata)
  );

  // The read register is unreset, so the response is masked by the flags
  assign inst_o       = (fvalid_q && !ferr_q) ? rdata : ZeroWord;
  assign inst_valid_o = fvalid_q;
  assign addr_err_o   = ferr_q;
  assign ld_ready_o   = (state_q == LdLoad);
  assign ld_busy_o    = (state_q == LdLoad);
  assign ld_done_o    = (state_q == LdDone);
  assign ld_count_o   = count_q;

endmodule
